// File: rtl/alu_serial_pkg.sv
// Shared opcodes, FSM state type and carry-seed helpers for the bit-serial ALU sequencer.
package alu_serial_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_INC   = 3'b100;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b101;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b110;
  localparam logic [OP_W-1:0] OP_BSUBA = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry-in for bit 0: increment and two's-complement subtracts start with 1.
  function automatic logic carry_seed(input logic [OP_W-1:0] op);
    logic seed;
    seed = 1'b0;
    case (op)
      OP_INC, OP_SUB, OP_BSUBA:         seed = 1'b1;
      OP_AND, OP_OR, OP_XOR, OP_XNOR,
      OP_ADD:                           seed = 1'b0;
      default:                          seed = 1'b0;
    endcase
    return seed;
  endfunction

  // Signed overflow is only meaningful for the two-operand add/subtract ops.
  function automatic logic ovf_en(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_BSUBA);
  endfunction

endpackage

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving an external combinational 1-bit ALU slice, LSB first.
// Optional z/c/v flag outputs are built when ALU_SERIAL_FLAGS_EN is defined.
module alu_serial_seq
  import alu_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic              ready_o,
  output logic              valid_o,
  input  logic              ack_i,
  output logic [WIDTH-1:0]  result_o,
`ifdef ALU_SERIAL_FLAGS_EN
  output logic              z_o,
  output logic              c_o,
  output logic              v_o,
`endif
  output logic              m_o,
  output logic              s1_o,
  output logic              s0_o,
  output logic              ai_o,
  output logic              bi_o,
  output logic              ci_o,
  input  logic              fi_i,
  input  logic              co_i
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic [OP_W-1:0]    op_q;
  logic               carry_q;
  logic               ready_q, valid_q;
  logic               accept_c, last_c;

  // Next-state decode; accept and last-bit strobes steer the datapath.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (count_q == CNT_W'(WIDTH - 1)) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand/op/carry registers are cleared on the last bit so slice drives read 0 outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
      if (accept_c) begin
        op_q    <= op_i;
        a_q     <= a_i;
        b_q     <= b_i;
        carry_q <= carry_seed(op_i);
        count_q <= '0;
      end else if (state_q == RUN) begin
        result_q <= {fi_i, result_q[WIDTH-1:1]};
        a_q      <= a_q >> 1;
        b_q      <= b_q >> 1;
        if (last_c) begin
          count_q <= '0;
          carry_q <= 1'b0;
          op_q    <= '0;
        end else begin
          count_q <= count_q + CNT_W'(1);
          carry_q <= co_i;
        end
      end
    end
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic z_q, c_q, v_q;

  // Flags are captured from the slice on the final bit, alongside the last result shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else if (last_c) begin
      z_q <= ({fi_i, result_q[WIDTH-1:1]} == '0);
      c_q <= co_i;
      v_q <= ovf_en(op_q) & (carry_q ^ co_i);
    end
  end

  assign z_o = z_q;
  assign c_o = c_q;
  assign v_o = v_q;
`endif

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign m_o      = op_q[2];
  assign s1_o     = op_q[1];
  assign s0_o     = op_q[0];
  assign ai_o     = a_q[0];
  assign bi_o     = b_q[0];
  assign ci_o     = carry_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq (WIDTH=8) with a behavioural 1-bit ALU slice in the loop.
module tb_alu_serial_seq;
  import alu_serial_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start, ack;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, result;
  logic             ready, valid;
  logic             m, s1, s0, ai, bi, ci, fi, co;
`ifdef ALU_SERIAL_FLAGS_EN
  logic             z_f, c_f, v_f;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .ready_o  (ready),
    .valid_o  (valid),
    .ack_i    (ack),
    .result_o (result),
`ifdef ALU_SERIAL_FLAGS_EN
    .z_o      (z_f),
    .c_o      (c_f),
    .v_o      (v_f),
`endif
    .m_o      (m),
    .s1_o     (s1),
    .s0_o     (s0),
    .ai_o     (ai),
    .bi_o     (bi),
    .ci_o     (ci),
    .fi_i     (fi),
    .co_i     (co)
  );

  // Reference 1-bit slice: logic ops when M=0, full adder on selected operands when M=1.
  always_comb begin
    logic x, y;
    fi = 1'b0;
    co = 1'b0;
    x  = 1'b0;
    y  = 1'b0;
    case ({m, s1, s0})
      3'b000: fi = ai & bi;
      3'b001: fi = ai | bi;
      3'b010: fi = ai ^ bi;
      3'b011: fi = ~(ai ^ bi);
      default: begin
        case ({s1, s0})
          2'b00:   begin x = ai;  y = 1'b0; end
          2'b01:   begin x = ai;  y = bi;   end
          2'b10:   begin x = ai;  y = ~bi;  end
          default: begin x = ~ai; y = bi;   end
        endcase
        fi = x ^ y ^ ci;
        co = (x & y) | (ci & (x ^ y));
      end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, input logic c, input logic v);
`ifdef ALU_SERIAL_FLAGS_EN
    check({tag, "_z"}, 64'(z_f), 64'(z));
    check({tag, "_c"}, 64'(c_f), 64'(c));
    check({tag, "_v"}, 64'(v_f), 64'(v));
`endif
  endtask

  // Accept an op, step through the WIDTH RUN cycles and land on the first DONE cycle.
  task automatic issue(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input bit hold);
    bit ci_zero, rdy_low;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(negedge clk);
    if (!hold) start = 1'b0;
    ci_zero = 1'b1;
    rdy_low = 1'b1;
    for (int k = 0; k < int'(WIDTH); k++) begin
      if (ci !== 1'b0) ci_zero = 1'b0;
      if (ready !== 1'b0 || valid !== 1'b0) rdy_low = 1'b0;
      if (hold) begin
        a  = ~a;
        b  = b + 8'h11;
        op = ~op;
      end
      @(negedge clk);
    end
    check({tag, "_valid_latency"}, 64'(valid), 64'd1);
    check({tag, "_ready_in_done"}, 64'(ready), 64'd0);
    if (hold) check({tag, "_ready_low_run"}, 64'(rdy_low), 64'd1);
    if (o[2] == 1'b0) check({tag, "_ci_zero_run"}, 64'(ci_zero), 64'd1);
    start = 1'b0;
  endtask

  // Hold off ack for wait_n cycles, then acknowledge and confirm the IDLE return.
  task automatic finish_op(input string tag, input logic [WIDTH-1:0] exp_res, input int wait_n);
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      check({tag, "_valid_held"}, 64'(valid), 64'd1);
      check({tag, "_result_held"}, 64'(result), 64'(exp_res));
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, "_ready_after_ack"}, 64'(ready), 64'd1);
    check({tag, "_valid_after_ack"}, 64'(valid), 64'd0);
    check({tag, "_result_kept_idle"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_slice", 64'({m, s1, s0, ai, bi, ci}), 64'd0);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Arithmetic ops
    issue("add_7f_01", 3'b101, 8'h7F, 8'h01, 1'b0);
    check_flags("add_7f_01", 1'b0, 1'b0, 1'b1);
    finish_op("add_7f_01", 8'h80, 0);

    issue("sub_05_07", 3'b110, 8'h05, 8'h07, 1'b0);
    check_flags("sub_05_07", 1'b0, 1'b0, 1'b0);
    finish_op("sub_05_07", 8'hFE, 0);

    issue("bsuba_05_07", 3'b111, 8'h05, 8'h07, 1'b0);
    check_flags("bsuba_05_07", 1'b0, 1'b1, 1'b0);
    finish_op("bsuba_05_07", 8'h02, 0);

    issue("inc_ff", 3'b100, 8'hFF, 8'h00, 1'b0);
    check_flags("inc_ff", 1'b1, 1'b1, 1'b0);
    finish_op("inc_ff", 8'h00, 0);

    // Logic ops
    issue("and", 3'b000, 8'hCA, 8'h0F, 1'b0);
    check_flags("and", 1'b0, 1'b0, 1'b0);
    finish_op("and", 8'h0A, 0);
    issue("or", 3'b001, 8'hCA, 8'h0F, 1'b0);
    finish_op("or", 8'hCF, 0);
    issue("xor", 3'b010, 8'hCA, 8'h0F, 1'b0);
    finish_op("xor", 8'hC5, 0);
    issue("xnor", 3'b011, 8'hCA, 8'h0F, 1'b0);
    finish_op("xnor", 8'h3A, 0);

    // start held high with changing operands during RUN
    issue("hold_start", 3'b101, 8'h12, 8'h34, 1'b1);
    check_flags("hold_start", 1'b0, 1'b0, 1'b0);
    finish_op("hold_start", 8'h46, 0);

    // ack withheld in DONE
    issue("ack_wait", 3'b101, 8'h20, 8'h22, 1'b0);
    finish_op("ack_wait", 8'h42, 5);

    // Reset at RUN bit 3
    @(negedge clk);
    start = 1'b1;
    op    = 3'b101;
    a     = 8'h55;
    b     = 8'h33;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_slice", 64'({m, s1, s0, ai, bi, ci}), 64'd0);
    issue("after_abort", 3'b101, 8'h03, 8'h04, 1'b0);
    finish_op("after_abort", 8'h07, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
